// File: rtl/viterbi_pkg.sv
// Shared types, constants and the PRBS step function for the Viterbi link test sequencer.
package viterbi_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DEC_LAT  = 16;
    localparam int unsigned TAIL_LEN = 2;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned BURST_W  = 8;
    localparam int unsigned MASK_W   = 2;

    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 16'h0001;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } seq_state_t;

    // Frame configuration captured when a start is accepted
    typedef struct packed {
        logic [CNT_W-1:0]   frame_len;
        logic [CNT_W-1:0]   burst_start;
        logic [BURST_W-1:0] burst_len;
        logic [MASK_W-1:0]  burst_mask;
    } seq_cfg_t;

    // Fibonacci shift-right step; the tap mask is bit-reversed so x^16 lands on bit 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < int'(LFSR_W); i++) begin
            if (LFSR_TAPS[int'(LFSR_W) - 1 - i]) fb = fb ^ s[i];
        end
        return {fb, s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/viterbi_link_sequencer_if.sv
// Control/status and encoder/decoder tap bundle of the link test sequencer.
interface viterbi_link_sequencer_if;
    import viterbi_pkg::*;

    logic                 start;
    logic [CNT_W-1:0]     frame_len;
    logic [CNT_W-1:0]     burst_start;
    logic [BURST_W-1:0]   burst_len;
    logic [MASK_W-1:0]    burst_mask;
    logic [LFSR_W-1:0]    seed;
    logic                 enc_enable;
    logic                 enc_bit;
    logic [MASK_W-1:0]    err_mask;
    logic                 dec_bit;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     inj_count;
    logic [CNT_W-1:0]     bit_err_count;

    modport master (
        output start, frame_len, burst_start, burst_len, burst_mask, seed, dec_bit,
        input  enc_enable, enc_bit, err_mask, busy, done, inj_count, bit_err_count
    );

    modport slave (
        input  start, frame_len, burst_start, burst_len, burst_mask, seed, dec_bit,
        output enc_enable, enc_bit, err_mask, busy, done, inj_count, bit_err_count
    );

endinterface

// File: rtl/viterbi_prbs16.sv
// 16-bit PRBS generator with load and step; exposes the bit that the next step will present.
module viterbi_prbs16
    import viterbi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic              o_next_bit_c
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    assign w_lfsr_next  = lfsr_step(r_lfsr);
    assign o_next_bit_c = w_lfsr_next[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_DEFAULT;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_step) begin
            r_lfsr <= w_lfsr_next;
        end
    end

endmodule

// File: rtl/viterbi_link_sequencer.sv
// Frame sequencer for the encoder -> channel -> Viterbi link: PRBS payload, zero tail,
// burst error-mask injection and scoring of decoder output against the sent payload.
module viterbi_link_sequencer
    import viterbi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    viterbi_link_sequencer_if.slave  bus
);

    localparam int unsigned PH_W  = 8;
    localparam int unsigned SUM_W = CNT_W + 1;

    seq_state_t                    r_state;
    seq_state_t                    w_next;
    logic                          w_accept;
    seq_cfg_t                      r_cfg;
    logic [CNT_W-1:0]              r_idx;
    logic [PH_W-1:0]               r_phase;
    logic                          r_enc_enable;
    logic                          r_enc_bit;
    logic                          r_pay;
    logic [MASK_W-1:0]             r_err_mask;
    logic                          r_busy;
    logic                          r_done;
    logic [CNT_W-1:0]              r_inj;
    logic [CNT_W-1:0]              r_berr;
    logic [DEC_LAT-1:0][1:0]       r_dly;
    logic [LFSR_W-1:0]             w_seed_eff;
    logic                          w_prbs_next_bit;
    logic                          w_in_burst;
    logic                          w_score_err;
    logic [SUM_W-1:0]              w_burst_end;

    assign w_seed_eff  = (bus.seed == '0) ? LFSR_DEFAULT : bus.seed;
    assign w_burst_end = {1'b0, r_cfg.burst_start} + SUM_W'(r_cfg.burst_len);
    assign w_in_burst  = (r_idx >= r_cfg.burst_start) && ({1'b0, r_idx} < w_burst_end);
    assign w_score_err = r_dly[DEC_LAT-1][1] && (r_dly[DEC_LAT-1][0] != bus.dec_bit);

    viterbi_prbs16 u_prbs (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_seed       (w_seed_eff),
        .i_step       ((r_state == RUN) && (w_next == RUN)),
        .o_next_bit_c (w_prbs_next_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.frame_len == '0) ? FLUSH : RUN;
                end
            end
            RUN:     if (r_idx == r_cfg.frame_len - CNT_W'(1)) w_next = FLUSH;
            FLUSH:   if (r_phase == PH_W'(TAIL_LEN - 1))        w_next = DRAIN;
            DRAIN:   if (r_phase == PH_W'(DEC_LAT - 1))         w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg        <= '0;
            r_idx        <= '0;
            r_phase      <= '0;
            r_enc_enable <= 1'b0;
            r_enc_bit    <= 1'b0;
            r_pay        <= 1'b0;
            r_err_mask   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_inj        <= '0;
            r_berr       <= '0;
            r_dly        <= '0;
        end else begin
            r_busy       <= (w_next != IDLE);
            r_done       <= (w_next == DONE);
            r_enc_enable <= (w_next == RUN) || (w_next == FLUSH);
            r_pay        <= (w_next == RUN);
            r_phase      <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_phase + PH_W'(1);

            if (w_next == RUN) r_enc_bit <= w_accept ? w_seed_eff[0] : w_prbs_next_bit;
            else               r_enc_bit <= 1'b0;

            r_err_mask <= ((r_state == RUN) && w_in_burst) ? r_cfg.burst_mask : '0;

            if (w_accept) begin
                r_cfg.frame_len   <= bus.frame_len;
                r_cfg.burst_start <= bus.burst_start;
                r_cfg.burst_len   <= bus.burst_len;
                r_cfg.burst_mask  <= bus.burst_mask;
                r_idx             <= '0;
                r_inj             <= '0;
                r_berr            <= '0;
            end else begin
                if (r_state == RUN) r_idx <= r_idx + CNT_W'(1);
                if ((r_state == RUN) && w_in_burst && (r_cfg.burst_mask != '0) && (r_inj != '1))
                    r_inj <= r_inj + CNT_W'(1);
                if (w_score_err && (r_berr != '1))
                    r_berr <= r_berr + CNT_W'(1);
            end

            // Payload flag rides with each sent bit so only payload is ever scored
            r_dly <= {r_dly[DEC_LAT-2:0], {r_pay, r_enc_bit}};
        end
    end

    assign bus.enc_enable    = r_enc_enable;
    assign bus.enc_bit       = r_enc_bit;
    assign bus.err_mask      = r_err_mask;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.inj_count     = r_inj;
    assign bus.bit_err_count = r_berr;

endmodule

// File: tb/tb_viterbi_link_sequencer.sv
// Self-checking bench for viterbi_link_sequencer: reference PRBS/timing model plus a delayed
// decoder channel with controllable bit flips.
module tb_viterbi_link_sequencer;
    import viterbi_pkg::*;

    localparam int LAT  = int'(DEC_LAT);
    localparam int TAIL = int'(TAIL_LEN);

    logic clk = 1'b0;
    logic rst = 1'b1;

    viterbi_link_sequencer_if bus();

    viterbi_link_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned tcyc   = 0;
    int          t_base = 0;
    int          cur_f  = 0;
    int          dmode  = 0;
    int          flips  = 0;
    logic [1:0]  hist[$];

    always @(posedge clk) tcyc <= tcyc + 1;

    // Decoder stand-in: dec_bit in cycle X is enc_bit of cycle X-LAT, optionally flipped
    always @(negedge clk) begin : chan
        int   r;
        logic fl;
        logic [1:0] e;
        r = int'(tcyc) - t_base;
        hist.push_back({(r >= 1 && r <= cur_f), bus.enc_bit});
        while (hist.size() > LAT + 1) void'(hist.pop_front());
        if (hist.size() == LAT + 1) begin
            e  = hist[0];
            fl = (dmode == 1) || (dmode == 2 && $urandom_range(0, 3) == 0);
            if (fl && e[1]) flips = flips + 1;
            bus.dec_bit = e[0] ^ fl;
        end else begin
            bus.dec_bit = 1'b0;
        end
    end

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic run_frame(input int f, input int bs, input int bl, input logic [1:0] bm,
                             input logic [15:0] sd, input int mode, input bit restart_mid);
        logic [15:0] s;
        bit          pay[$];
        int          exp_inj, exp_berr, total, idx;
        logic        e_en, e_bit, e_busy, e_done;
        logic [1:0]  e_mask;
        s = (sd == 16'h0) ? 16'h0001 : sd;
        for (int i = 0; i < f; i++) begin
            pay.push_back(s[0]);
            s = ref_step(s);
        end
        exp_inj = 0;
        if (bm != 2'b00)
            for (int i = 0; i < f; i++) if (i >= bs && i < bs + bl) exp_inj++;
        total = f + TAIL + LAT + 1;

        @(negedge clk);
        bus.frame_len   = 16'(f);
        bus.burst_start = 16'(bs);
        bus.burst_len   = 8'(bl);
        bus.burst_mask  = bm;
        bus.seed        = sd;
        bus.start       = 1'b1;
        dmode           = mode;
        flips           = 0;
        @(posedge clk);
        #1;
        t_base    = int'(tcyc) - 1;
        cur_f     = f;
        bus.start = 1'b0;

        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            idx    = c - 2;
            e_busy = (c <= total);
            e_done = (c == total);
            e_en   = (c <= f + TAIL);
            e_bit  = (c <= f) ? pay[c-1] : 1'b0;
            e_mask = (idx >= 0 && idx < f && idx >= bs && idx < bs + bl) ? bm : 2'b00;
            checks += 5;
            if (bus.busy !== e_busy) begin
                errors++;
                $display("FAIL busy f=%0d cycle=%0d got=%b exp=%b", f, c, bus.busy, e_busy);
            end
            if (bus.done !== e_done) begin
                errors++;
                $display("FAIL done f=%0d cycle=%0d got=%b exp=%b", f, c, bus.done, e_done);
            end
            if (bus.enc_enable !== e_en) begin
                errors++;
                $display("FAIL enc_enable f=%0d cycle=%0d got=%b exp=%b", f, c, bus.enc_enable, e_en);
            end
            if (bus.enc_bit !== e_bit) begin
                errors++;
                $display("FAIL enc_bit f=%0d cycle=%0d got=%b exp=%b", f, c, bus.enc_bit, e_bit);
            end
            if (bus.err_mask !== e_mask) begin
                errors++;
                $display("FAIL err_mask f=%0d cycle=%0d got=%b exp=%b", f, c, bus.err_mask, e_mask);
            end
            if (restart_mid && c == 3) begin
                bus.start     = 1'b1;
                bus.frame_len = 16'(f + 7);
                bus.seed      = ~sd;
            end
            if (restart_mid && c == 4) bus.start = 1'b0;
        end

        exp_berr = (mode == 1) ? f : (mode == 2) ? flips : 0;
        checks += 2;
        if (bus.inj_count !== 16'(exp_inj)) begin
            errors++;
            $display("FAIL inj_count f=%0d got=%0d exp=%0d", f, bus.inj_count, exp_inj);
        end
        if (bus.bit_err_count !== 16'(exp_berr)) begin
            errors++;
            $display("FAIL bit_err_count f=%0d got=%0d exp=%0d", f, bus.bit_err_count, exp_berr);
        end
        cur_f = 0;
        dmode = 0;
    endtask

    task automatic test_reset();
        bus.start       = 1'b0;
        bus.frame_len   = '0;
        bus.burst_start = '0;
        bus.burst_len   = '0;
        bus.burst_mask  = '0;
        bus.seed        = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.enc_enable !== 1'b0) begin errors++; $display("FAIL reset enc_enable got=%b exp=0", bus.enc_enable); end
        if (bus.enc_bit    !== 1'b0) begin errors++; $display("FAIL reset enc_bit got=%b exp=0", bus.enc_bit); end
        if (bus.err_mask   !== 2'b00) begin errors++; $display("FAIL reset err_mask got=%b exp=00", bus.err_mask); end
        if (bus.busy       !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        if (bus.done       !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", bus.done); end
        if (bus.inj_count  !== 16'd0) begin errors++; $display("FAIL reset inj_count got=%0d exp=0", bus.inj_count); end
        if (bus.bit_err_count !== 16'd0) begin errors++; $display("FAIL reset bit_err_count got=%0d exp=0", bus.bit_err_count); end
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        run_frame(8, 0, 0, 2'b11, 16'($urandom_range(1, 65535)), 0, 1'b0);
    endtask

    task automatic test_burst();
        run_frame(64, 5, 3, 2'b10, 16'hACE1, 0, 1'b0);
        run_frame(10, 65534, 255, 2'b11, 16'h1234, 0, 1'b0);
        run_frame(12, 9, 40, 2'b00, 16'h0F0F, 0, 1'b0);
    endtask

    task automatic test_inverted();
        run_frame(20, 0, 0, 2'b00, 16'hBEEF, 1, 1'b0);
    endtask

    task automatic test_link_single_error();
        run_frame(200, $urandom_range(0, 199), 1, 2'b01, 16'($urandom_range(1, 65535)), 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame(30, 2, 4, 2'b11, 16'h5A5A, 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        bus.frame_len  = 16'd40;
        bus.burst_start = 16'd0;
        bus.burst_len  = 8'd20;
        bus.burst_mask = 2'b11;
        bus.seed       = 16'h7777;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 7;
        if (bus.enc_enable !== 1'b0) begin errors++; $display("FAIL midreset enc_enable got=%b exp=0", bus.enc_enable); end
        if (bus.enc_bit    !== 1'b0) begin errors++; $display("FAIL midreset enc_bit got=%b exp=0", bus.enc_bit); end
        if (bus.err_mask   !== 2'b00) begin errors++; $display("FAIL midreset err_mask got=%b exp=00", bus.err_mask); end
        if (bus.busy       !== 1'b0) begin errors++; $display("FAIL midreset busy got=%b exp=0", bus.busy); end
        if (bus.done       !== 1'b0) begin errors++; $display("FAIL midreset done got=%b exp=0", bus.done); end
        if (bus.inj_count  !== 16'd0) begin errors++; $display("FAIL midreset inj_count got=%0d exp=0", bus.inj_count); end
        if (bus.bit_err_count !== 16'd0) begin errors++; $display("FAIL midreset bit_err_count got=%0d exp=0", bus.bit_err_count); end
        #2 rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks += 2;
            if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_nodone cycle=%0d got=%b exp=0", c, bus.done); end
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_idle cycle=%0d got=%b exp=0", c, bus.busy); end
        end
    endtask

    task automatic test_zero_len_seed0();
        run_frame(0, 0, 5, 2'b11, 16'h0000, 0, 1'b0);
        run_frame(16, 0, 0, 2'b00, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_frame($urandom_range(1, 60), $urandom_range(0, 70), $urandom_range(0, 20),
                      2'($urandom_range(0, 3)), 16'($urandom), 2, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(5, 1, 2, 2'b01, 16'h0003, 2, 1'b0);
        run_frame(7, 0, 7, 2'b10, 16'h8001, 1, 1'b0);
    endtask

    initial begin
        bus.dec_bit = 1'b0;
        test_reset();
        test_nominal();
        test_burst();
        test_inverted();
        test_link_single_error();
        test_start_ignored();
        test_reset_mid_frame();
        test_zero_len_seed0();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
